// File: rtl/bus_cycle_sched.sv
// bus_cycle_sched: round-robin arbiter and T1-T4 bus cycle sequencer for a
// shared 8088-style system bus, with wait-state insertion, wait timeout and
// chip-select decode.
//
// Ports:
//   CLK, RESET                 bus clock, asynchronous active-high reset
//   req*/iom*/we*/addr*/wdata* requester transaction (level request)
//   gnt0, gnt1                 request captured (combinational, IDLE only)
//   done0, done1, err          cycle completion pulse, timeout flag
//   rdata                      read data, valid with done, held otherwise
//   ALE, IOM, RD, WR, A        bus control / address (RD, WR active low)
//   D_out, D_oe, D_in          bus data out / drive enable / data in
//   READY                      device ready, sampled in T3 and TW only
//   CS                         one-hot chip selects, held T1..T4
module bus_cycle_sched #(
  parameter int unsigned WAIT_MAX   = 8,
  parameter logic [7:0]  IO_HI_BASE = 8'hFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req0,
  input  logic        req1,
  input  logic        iom0,
  input  logic        iom1,
  input  logic        we0,
  input  logic        we1,
  input  logic [19:0] addr0,
  input  logic [19:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        ALE,
  output logic        IOM,
  output logic        RD,
  output logic        WR,
  output logic [19:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  input  logic        READY,
  output logic [3:0]  CS
);

  localparam int unsigned AW    = 20;
  localparam int unsigned DW    = 8;
  localparam int unsigned CSW   = 4;
  localparam int unsigned CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_TW   = 3'd4,
    S_T4   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;      // 1: req1 wins a tie next time
  logic             owner_q, owner_d;    // requester owning the bus cycle
  logic             we_q, we_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             ale_q, ale_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             doe_q, doe_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic [AW-1:0]    a_q, a_d;
  logic             iom_q, iom_d;
  logic [CSW-1:0]   cs_q, cs_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err_q, err_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic             sel1_c;      // req1 wins arbitration this cycle
  logic             req_any_c;
  logic             end_cyc_c;   // current cycle moves to T4
  logic             tmo_c;       // move to T4 is a timeout abort

  // Chip-select decode of a captured request
  function automatic logic [CSW-1:0] cs_decode(input logic iom, input logic [AW-1:0] addr);
    logic [CSW-1:0] cs;
    if (!iom) begin
      cs = addr[19] ? CSW'(4'b0010) : CSW'(4'b0001);
    end else begin
      cs = (addr[15:8] == IO_HI_BASE) ? CSW'(4'b0100) : CSW'(4'b1000);
    end
    return cs;
  endfunction

  // Round-robin: a lone requester wins; on a tie the one not granted last wins
  assign req_any_c = req0 || req1;
  assign sel1_c    = req1 && (!req0 || prio_q);

  // Grant is visible in the IDLE cycle whose closing edge captures the request
  assign gnt0 = (state_q == S_IDLE) && req_any_c && !sel1_c;
  assign gnt1 = (state_q == S_IDLE) && sel1_c;

  assign done0 = done0_q;
  assign done1 = done1_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign ALE   = ale_q;
  assign IOM   = iom_q;
  assign RD    = rd_q;
  assign WR    = wr_q;
  assign A     = a_q;
  assign D_out = dout_q;
  assign D_oe  = doe_q;
  assign CS    = cs_q;

  // State and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wcnt_q  <= '0;
      ale_q   <= 1'b0;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      doe_q   <= 1'b0;
      dout_q  <= '0;
      a_q     <= '0;
      iom_q   <= 1'b0;
      cs_q    <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      ale_q   <= ale_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      doe_q   <= doe_d;
      dout_q  <= dout_d;
      a_q     <= a_d;
      iom_q   <= iom_d;
      cs_q    <= cs_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wcnt_d    = wcnt_q;
    ale_d     = 1'b0;
    rd_d      = rd_q;
    wr_d      = wr_q;
    doe_d     = doe_q;
    dout_d    = dout_q;
    a_d       = a_q;
    iom_d     = iom_q;
    cs_d      = cs_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    end_cyc_c = 1'b0;
    tmo_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_any_c) begin
          state_d = S_T1;
          ale_d   = 1'b1;
          owner_d = sel1_c;
          prio_d  = !sel1_c;
          we_d    = sel1_c ? we1    : we0;
          wdata_d = sel1_c ? wdata1 : wdata0;
          a_d     = sel1_c ? addr1  : addr0;
          iom_d   = sel1_c ? iom1   : iom0;
          cs_d    = sel1_c ? cs_decode(iom1, addr1) : cs_decode(iom0, addr0);
          wcnt_d  = '0;
        end
      end
      S_T1: begin
        state_d = S_T2;
        rd_d    = we_q;
        wr_d    = !we_q;
        doe_d   = we_q;
        if (we_q) begin
          dout_d = wdata_q;
        end
      end
      S_T2: begin
        state_d = S_T3;
      end
      S_T3: begin
        if (READY) begin
          end_cyc_c = 1'b1;
        end else begin
          state_d = S_TW;
          wcnt_d  = CNT_W'(1);
        end
      end
      S_TW: begin
        if (READY) begin
          end_cyc_c = 1'b1;
        end else if (wcnt_q == CNT_W'(WAIT_MAX)) begin
          end_cyc_c = 1'b1;
          tmo_c     = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_T4: begin
        state_d = S_IDLE;
        cs_d    = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Common T3/TW exit: release strobes, report completion, latch read data
    if (end_cyc_c) begin
      state_d = S_T4;
      rd_d    = 1'b1;
      wr_d    = 1'b1;
      doe_d   = 1'b0;
      done0_d = !owner_q;
      done1_d = owner_q;
      err_d   = tmo_c;
      if (!we_q && !tmo_c) begin
        rdata_d = D_in;
      end
    end
  end

endmodule
